ld_mem_fetch: RTL and testbench

- Memory-read front end for the load stage of the 16-bit datapath.
- Accepts a load instruction and, for memory-sourced loads (ins[10]=0), issues a read of address ins[7:0] to data memory and waits for the acknowledge.
- Registers the returned word and the instruction together and presents them to the load stage's data/ins inputs with a valid/ready handshake.
- Immediate loads (ins[10]=1) bypass memory.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/ld_wait_timer.sv | 36 +++
 rtl/ld_mem_fetch.sv | 110 +++++++++++
 tb/tb_ld_mem_fetch.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared load-path types and constants
package cpu_pkg;

  localparam int DW_DEFAULT  = 16;
  localparam int AW_DEFAULT  = 8;
  localparam int LD_SRC_BIT  = 10;
  localparam int LD_HALF_BIT = 9;
  localparam int ADDR_LSB    = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } ld_state_e;

endpackage

// File: rtl/ld_wait_timer.sv
// rtl/ld_wait_timer.sv - wait-cycle counter flagging the last allowed memory wait cycle
module ld_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/ld_mem_fetch.sv
// rtl/ld_mem_fetch.sv - load-stage memory read front end with ack timeout
module ld_mem_fetch
  import cpu_pkg::*;
#(
  parameter int DW             = DW_DEFAULT,
  parameter int AW             = AW_DEFAULT,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ins_valid,
  input  logic [DW-1:0] ins,
  output logic          ins_ready,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] data_out,
  output logic [DW-1:0] ins_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          timeout_err
);

  ld_state_e     state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] ins_q, ins_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          terr_q, terr_d;
  logic          tmr_clear, tmr_enable, tmr_expired;

  // Ack takes priority: the timer only runs on cycles without an ack.
  assign tmr_enable = (state_q == WAIT) && !mem_ack;

  ld_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    ins_d     = ins_q;
    addr_d    = addr_q;
    terr_d    = 1'b0;
    tmr_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (ins_valid) begin
          ins_d     = ins;
          addr_d    = ins[ADDR_LSB +: AW];
          tmr_clear = 1'b1;
          if (ins[LD_SRC_BIT]) begin
            data_d  = '0;
            state_d = HOLD;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = HOLD;
        end else if (tmr_expired) begin
          data_d  = '0;
          terr_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      ins_q   <= '0;
      addr_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ins_q   <= ins_d;
      addr_q  <= addr_d;
      terr_q  <= terr_d;
    end
  end

  // Handshake outputs decode the state register so reset drops them at once.
  assign mem_req     = (state_q == WAIT);
  assign ins_ready   = (state_q == IDLE);
  assign out_valid   = (state_q == HOLD);
  assign mem_addr    = addr_q;
  assign data_out    = data_q;
  assign ins_out     = ins_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_ld_mem_fetch.sv
// tb/tb_ld_mem_fetch.sv - randomized self-checking bench for ld_mem_fetch
module tb_ld_mem_fetch;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int TO = 15;

  logic          clk, rst_n;
  logic          ins_valid, ins_ready, mem_req, mem_ack;
  logic          out_valid, out_ready, timeout_err;
  logic [DW-1:0] ins, mem_rdata, data_out, ins_out;
  logic [AW-1:0] mem_addr;

  int n_chk  = 0;
  int n_pass = 0;

  ld_mem_fetch #(.DW(DW), .AW(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ins_valid  (ins_valid),
    .ins        (ins),
    .ins_ready  (ins_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .data_out   (data_out),
    .ins_out    (ins_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One load transaction. ack_at = WAIT cycle (1-based) that sees mem_ack; outside 1..TO means never.
  task automatic do_txn(input logic [15:0] iv, input int ack_at, input logic [15:0] rd, input int stall);
    int          lat, reqc, exp_lat, exp_req;
    logic [15:0] exp_data;
    logic        exp_terr;
    if (iv[10]) begin
      exp_lat = 1; exp_req = 0; exp_data = 16'h0; exp_terr = 1'b0;
    end else if (ack_at >= 1 && ack_at <= TO) begin
      exp_lat = ack_at + 1; exp_req = ack_at; exp_data = rd; exp_terr = 1'b0;
    end else begin
      exp_lat = TO + 1; exp_req = TO; exp_data = 16'h0; exp_terr = 1'b1;
    end
    chk("idle_ins_ready", 32'(ins_ready), 32'(1));
    ins_valid = 1'b1; ins = iv; mem_ack = 1'b0; out_ready = 1'b0;
    tick();
    ins_valid = 1'b0; ins = 16'($urandom);
    lat = 1; reqc = 0;
    while (!out_valid && lat < 40) begin
      if (mem_req) begin
        reqc++;
        chk("mem_addr", 32'(mem_addr), 32'(iv[7:0]));
        mem_ack   = (reqc == ack_at);
        mem_rdata = mem_ack ? rd : 16'($urandom);
      end else begin
        mem_ack = 1'b0;
      end
      tick();
      lat++;
    end
    mem_ack   = 1'($urandom);
    mem_rdata = 16'($urandom);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("req_cycles", 32'(reqc), 32'(exp_req));
    chk("out_valid", 32'(out_valid), 32'(1));
    chk("data_out", 32'(data_out), 32'(exp_data));
    chk("ins_out", 32'(ins_out), 32'(iv));
    chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
    chk("hold_ins_ready", 32'(ins_ready), 32'(0));
    chk("hold_mem_req", 32'(mem_req), 32'(0));
    for (int s = 0; s < stall; s++) begin
      ins_valid = 1'b1; ins = 16'($urandom); mem_ack = 1'($urandom);
      tick();
      chk("stall_valid", 32'(out_valid), 32'(1));
      chk("stall_data", 32'(data_out), 32'(exp_data));
      chk("stall_ins", 32'(ins_out), 32'(iv));
      chk("stall_terr", 32'(timeout_err), 32'(0));
      chk("stall_ins_ready", 32'(ins_ready), 32'(0));
    end
    out_ready = 1'b1; ins_valid = 1'b1; ins = 16'($urandom);
    tick();
    chk("release_valid", 32'(out_valid), 32'(0));
    chk("release_ins_ready", 32'(ins_ready), 32'(1));
    chk("release_no_accept", 32'(ins_out), 32'(iv));
    chk("release_terr", 32'(timeout_err), 32'(0));
    out_ready = 1'b0; ins_valid = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'(0));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_data_out"}, 32'(data_out), 32'(0));
    chk({tag, "_ins_out"}, 32'(ins_out), 32'(0));
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(0));
    chk({tag, "_ins_ready"}, 32'(ins_ready), 32'(1));
  endtask

  initial begin
    rst_n = 1'b1; ins_valid = 1'b0; ins = '0; mem_ack = 1'b0;
    mem_rdata = '0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_txn(16'h0012, 1, 16'hBEEF, 0);
    do_txn(16'h0634, 0, 16'h0000, 0);
    do_txn(16'h0040, 0, 16'h0000, 0);
    do_txn(16'h0077, TO, 16'h1234, 0);
    do_txn(16'h0099, 3, 16'hA5A5, 5);

    for (int i = 0; i < 40; i++) begin
      do_txn(16'($urandom), int'($urandom_range(0, 17)), 16'($urandom),
             int'($urandom_range(0, 3)));
    end

    ins_valid = 1'b1; ins = 16'h0055;
    tick();
    ins_valid = 1'b0;
    tick();
    tick();
    chk("pre_reset_mem_req", 32'(mem_req), 32'(1));
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_txn(16'h00A1, 2, 16'h5A5A, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
